// File: rtl/mem_responder.sv
// mem_responder: 16-bit word memory behind a req/ready handshake, with a fixed
// number of wait states before each response and misaligned/out-of-range errors.
module mem_responder #(
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [15:0] addr_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] rdata_o,
    output logic        ready_o,
    output logic        err_o,
    output logic        busy_o
);
    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q;
    logic [15:0]   addr_q;
    logic [15:0]   wdata_q;
    logic          err_q;
    logic [15:0]   rdata_q;
    logic [15:0]   mem_q [DEPTH];

    logic          accept;
    logic          txn_we;
    logic [15:0]   txn_addr;
    logic [15:0]   txn_wdata;
    logic          txn_err;
    logic [AW-1:0] txn_idx;
    logic          commit;

    assign accept = (state_q == ST_IDLE) && req_i;

    // With WAIT=0 the transaction commits on its own acceptance edge, so the
    // fields are taken straight from the ports in that cycle.
    assign txn_we    = accept ? we_i    : we_q;
    assign txn_addr  = accept ? addr_i  : addr_q;
    assign txn_wdata = accept ? wdata_i : wdata_q;
    assign txn_err   = txn_addr[0] || ({1'b0, txn_addr[15:1]} >= 17'(DEPTH));
    assign txn_idx   = txn_addr[AW:1];

    assign commit = (state_d == ST_RESP) && (state_q != ST_RESP) && !txn_err && !reset_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    state_d = (WAIT > 0) ? ST_WAIT : ST_RESP;
                    cnt_d   = WAIT_INIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            err_q   <= 1'b0;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                err_q   <= txn_err;
            end
            if (commit && !txn_we) rdata_q <= mem_q[txn_idx];
        end
    end

    // NOTE: no reset branch here; contents survive reset, and commit already
    // excludes a write falling on a reset edge.
    always_ff @(posedge clk_i) begin
        if (commit && txn_we) mem_q[txn_idx] <= txn_wdata;
    end

    always_comb begin
        ready_o = (state_q == ST_RESP);
        err_o   = (state_q == ST_RESP) && err_q;
        busy_o  = (state_q != ST_IDLE);
        rdata_o = rdata_q;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: instance A runs with WAIT=2, instance B with
// WAIT=0; a reference memory model predicts err, rdata and the response cycle.
module tb_mem_responder;
    localparam int DEPTH  = 256;
    localparam int WAIT_A = 2;
    localparam int WAIT_B = 0;

    typedef struct {
        logic        err;
        logic [15:0] rdata;
        int          cyc;
    } exp_t;

    typedef struct {
        bit          got;
        logic        err;
        logic [15:0] rdata;
        int          cyc;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, req_a, we_a, ready_a, err_a, busy_a;
    logic [15:0] addr_a, wdata_a, rdata_a;
    logic        reset_b, req_b, we_b, ready_b, err_b, busy_b;
    logic [15:0] addr_b, wdata_b, rdata_b;

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    int rdy_a = 0, rdy_b = 0;
    int push_a = 0, push_b = 0;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [15:0] mem_a [DEPTH];
    logic [15:0] mem_b [DEPTH];
    logic [15:0] rd_a = 16'h0000;
    logic [15:0] rd_b = 16'h0000;

    mem_responder #(.DEPTH(DEPTH), .WAIT(WAIT_A)) u_dut_a (
        .clk_i(clk), .reset_i(reset_a), .req_i(req_a), .we_i(we_a),
        .addr_i(addr_a), .wdata_i(wdata_a), .rdata_o(rdata_a),
        .ready_o(ready_a), .err_o(err_a), .busy_o(busy_a)
    );

    mem_responder #(.DEPTH(DEPTH), .WAIT(WAIT_B)) u_dut_b (
        .clk_i(clk), .reset_i(reset_b), .req_i(req_b), .we_i(we_b),
        .addr_i(addr_b), .wdata_i(wdata_b), .rdata_o(rdata_b),
        .ready_o(ready_b), .err_o(err_b), .busy_o(busy_b)
    );

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (ready_a) rdy_a <= rdy_a + 1;
        if (ready_b) rdy_b <= rdy_b + 1;
    end

    // Drives one request for one cycle, predicts its response, then scrambles the
    // inputs so a DUT that does not latch them responds wrongly.
    task automatic send(input bit sel, input logic w, input logic [15:0] a, input logic [15:0] d);
        exp_t ex;
        int   idx;
        idx    = int'(a[15:1]);
        ex.err = a[0] || (idx >= DEPTH);
        ex.cyc = cyc + 1 + (sel ? WAIT_B : WAIT_A);
        if (!sel) begin
            if (!ex.err) begin
                if (w) mem_a[idx] = d;
                else   rd_a = mem_a[idx];
            end
            ex.rdata = rd_a;
            q_a.push_back(ex);
            push_a++;
            req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d;
            @(negedge clk);
            req_a = 1'b0; we_a = ~w; addr_a = ~a; wdata_a = ~d;
        end else begin
            if (!ex.err) begin
                if (w) mem_b[idx] = d;
                else   rd_b = mem_b[idx];
            end
            ex.rdata = rd_b;
            q_b.push_back(ex);
            push_b++;
            req_b = 1'b1; we_b = w; addr_b = a; wdata_b = d;
            @(negedge clk);
            req_b = 1'b0; we_b = ~w; addr_b = ~a; wdata_b = ~d;
        end
    endtask

    task automatic await_ready(input bit sel, output obs_t o);
        o.got = 1'b0; o.err = 1'bx; o.rdata = 16'hxxxx; o.cyc = -1;
        for (int i = 0; i < 20; i++) begin
            if (sel ? ready_b : ready_a) begin
                o.got   = 1'b1;
                o.err   = sel ? err_b : err_a;
                o.rdata = sel ? rdata_b : rdata_a;
                o.cyc   = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic txn(input bit sel, input logic w, input logic [15:0] a, input logic [15:0] d,
                       output obs_t o, output exp_t ex);
        send(sel, w, a, d);
        await_ready(sel, o);
        ex = sel ? q_b.pop_front() : q_a.pop_front();
    endtask

    task automatic test_reset;
        reset_a = 1'b1; reset_b = 1'b1;
        req_a = 1'b1; req_b = 1'b1; we_a = 1'b0; we_b = 1'b0;
        addr_a = 16'h0000; addr_b = 16'h0000; wdata_a = 16'h0; wdata_b = 16'h0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({ready_a, err_a, busy_a, rdata_a, ready_b, err_b, busy_b, rdata_b} !== 38'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: A r/e/b/d=%b/%b/%b/%h B=%b/%b/%b/%h, required all zero",
                     ready_a, err_a, busy_a, rdata_a, ready_b, err_b, busy_b, rdata_b);
        end
        reset_a = 1'b0; reset_b = 1'b0; req_a = 1'b0; req_b = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({busy_a, busy_b} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_ignores_req: busy A/B=%b/%b, required 0/0", busy_a, busy_b);
        end
    endtask

    task automatic test_basic;
        logic        tw [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] ta [5] = '{16'h0010, 16'h0010, 16'h0011, 16'h0011, 16'h0010};
        logic [15:0] td [5] = '{16'hBEEF, 16'h0000, 16'h0000, 16'hDEAD, 16'h0000};
        obs_t o;
        exp_t ex;
        for (int i = 0; i < 5; i++) begin
            txn(1'b0, tw[i], ta[i], td[i], o, ex);
            n_vec++;
            if (!o.got || o.err !== ex.err || o.rdata !== ex.rdata || o.cyc != ex.cyc) begin
                n_bad++;
                $display("FAIL basic[%0d]: got=%0b err=%b rdata=%h cyc=%0d, required err=%b rdata=%h cyc=%0d",
                         i, o.got, o.err, o.rdata, o.cyc, ex.err, ex.rdata, ex.cyc);
            end
        end
    endtask

    task automatic test_range;
        logic        tw [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [15:0] ta [7] = '{16'h0000, 16'h01FE, 16'h0200, 16'hFFFE, 16'h0000, 16'h01FE, 16'h0201};
        logic [15:0] td [7] = '{16'h5A5A, 16'h7777, 16'h1111, 16'h2222, 16'h0, 16'h0, 16'h0};
        obs_t o;
        exp_t ex;
        for (int i = 0; i < 7; i++) begin
            txn(1'b0, tw[i], ta[i], td[i], o, ex);
            n_vec++;
            if (!o.got || o.err !== ex.err || o.rdata !== ex.rdata || o.cyc != ex.cyc) begin
                n_bad++;
                $display("FAIL range[%0d]: got=%0b err=%b rdata=%h cyc=%0d, required err=%b rdata=%h cyc=%0d",
                         i, o.got, o.err, o.rdata, o.cyc, ex.err, ex.rdata, ex.cyc);
            end
        end
    endtask

    task automatic test_wait0;
        obs_t o;
        exp_t ex;
        for (int i = 0; i < 4; i++) begin
            txn(1'b1, 1'b1, 16'(2 * i), 16'h1000 + 16'(i), o, ex);
            n_vec++;
            if (!o.got || o.err !== ex.err || o.cyc != ex.cyc) begin
                n_bad++;
                $display("FAIL wait0_prewrite[%0d]: got=%0b err=%b cyc=%0d, required err=%b cyc=%0d",
                         i, o.got, o.err, o.cyc, ex.err, ex.cyc);
            end
        end
        req_b = 1'b1; we_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr_b  = 16'(2 * i);
            rd_b    = mem_b[i];
            ex.err  = 1'b0;
            ex.rdata = rd_b;
            ex.cyc  = cyc + 1;
            q_b.push_back(ex);
            push_b++;
            @(negedge clk);
            ex = q_b.pop_front();
            n_vec++;
            if (ready_b !== 1'b1 || busy_b !== 1'b1 || err_b !== 1'b0 ||
                rdata_b !== ex.rdata || cyc != ex.cyc) begin
                n_bad++;
                $display("FAIL wait0_stream[%0d]: ready=%b busy=%b err=%b rdata=%h cyc=%0d, required 1/1/0 rdata=%h cyc=%0d",
                         i, ready_b, busy_b, err_b, rdata_b, cyc, ex.rdata, ex.cyc);
            end
            addr_b = 16'hFFFF;
            @(negedge clk);
            n_vec++;
            if (ready_b !== 1'b0 || busy_b !== 1'b0) begin
                n_bad++;
                $display("FAIL wait0_gap[%0d]: ready=%b busy=%b, required 0/0", i, ready_b, busy_b);
            end
        end
        req_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        logic [15:0] keep [2] = '{16'hAAAA, 16'h5555};
        obs_t o;
        exp_t ex;
        int   stray;
        for (int d = 1; d <= 2; d++) begin
            txn(1'b0, 1'b1, 16'h0004, keep[d-1], o, ex);
            n_vec++;
            if (!o.got || o.err !== ex.err || o.cyc != ex.cyc) begin
                n_bad++;
                $display("FAIL abort_prewrite[%0d]: got=%0b err=%b cyc=%0d, required err=%b cyc=%0d",
                         d, o.got, o.err, o.cyc, ex.err, ex.cyc);
            end
            req_a = 1'b1; we_a = 1'b1; addr_a = 16'h0004; wdata_a = 16'h1234;
            @(negedge clk);
            req_a = 1'b0;
            repeat (d - 1) @(negedge clk);
            reset_a = 1'b1; req_a = 1'b1; we_a = 1'b0;
            @(negedge clk);
            reset_a = 1'b0; req_a = 1'b0;
            rd_a = 16'h0000;
            n_vec++;
            if ({ready_a, err_a, busy_a, rdata_a} !== 19'h0) begin
                n_bad++;
                $display("FAIL abort_outputs[%0d]: r/e/b/d=%b/%b/%b/%h, required all zero",
                         d, ready_a, err_a, busy_a, rdata_a);
            end
            stray = 0;
            for (int j = 0; j < 5; j++) begin
                @(negedge clk);
                if (ready_a !== 1'b0 || busy_a !== 1'b0) stray++;
            end
            n_vec++;
            if (stray != 0) begin
                n_bad++;
                $display("FAIL abort_quiet[%0d]: %0d cycles with ready/busy set, required 0", d, stray);
            end
            txn(1'b0, 1'b0, 16'h0004, 16'h0000, o, ex);
            n_vec++;
            if (!o.got || o.err !== ex.err || o.rdata !== ex.rdata || o.cyc != ex.cyc) begin
                n_bad++;
                $display("FAIL abort_readback[%0d]: got=%0b err=%b rdata=%h cyc=%0d, required err=%b rdata=%h cyc=%0d",
                         d, o.got, o.err, o.rdata, o.cyc, ex.err, ex.rdata, ex.cyc);
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_t ex;
        int   k;
        k = cyc;
        rd_a = mem_a[8];
        for (int n = 0; n < 3; n++) begin
            ex.err   = 1'b0;
            ex.rdata = rd_a;
            ex.cyc   = k + 1 + 4 * n + WAIT_A;
            q_a.push_back(ex);
            push_a++;
        end
        req_a = 1'b1; we_a = 1'b0; addr_a = 16'h0010; wdata_a = 16'h0000;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            if (j == 10) req_a = 1'b0;
            if (ready_a) begin
                n_vec++;
                if (q_a.size() == 0) begin
                    n_bad++;
                    $display("FAIL b2b_extra: ready at cyc=%0d, required none", cyc);
                end else begin
                    ex = q_a.pop_front();
                    if (err_a !== ex.err || rdata_a !== ex.rdata || cyc != ex.cyc) begin
                        n_bad++;
                        $display("FAIL b2b_resp: err=%b rdata=%h cyc=%0d, required err=%b rdata=%h cyc=%0d",
                                 err_a, rdata_a, cyc, ex.err, ex.rdata, ex.cyc);
                    end
                end
            end
        end
        n_vec++;
        if (q_a.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_missing: %0d responses outstanding, required 0", q_a.size());
            q_a.delete();
        end
    endtask

    initial begin
        reset_a = 1'b1; reset_b = 1'b1;
        req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
        addr_a = 16'h0; addr_b = 16'h0; wdata_a = 16'h0; wdata_b = 16'h0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_range();
        test_wait0();
        test_reset_abort();
        test_back_to_back();
        repeat (3) @(negedge clk);
        n_vec++;
        if (rdy_a != push_a || rdy_b != push_b) begin
            n_bad++;
            $display("FAIL ready_count: A=%0d B=%0d pulses, required A=%0d B=%0d",
                     rdy_a, rdy_b, push_a, push_b);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
